// File: rtl/ariane_pkg.sv
// Shared core types: scoreboard entry record, exception record, functional-unit
// tags and the default scoreboard geometry.
package ariane_pkg;

  localparam int NR_SB_ENTRIES = 4;
  localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
  localparam int NR_WB_PORTS   = 2;

  typedef enum logic [2:0] {
    FU_NONE,
    FU_LOAD,
    FU_STORE,
    FU_ALU,
    FU_CTRL_FLOW,
    FU_MULT,
    FU_CSR
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    logic [6:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    logic                     use_imm;
    exception                 ex;
  } scoreboard_entry;

endpackage

// File: rtl/scoreboard_pkg.sv
// Scoreboard-local helpers: the circular-buffer pointer type and its
// modulo-depth advance.
package scoreboard_pkg;

  import ariane_pkg::*;

  typedef logic [TRANS_ID_BITS-1:0] sb_ptr_t;

  // Pointer arithmetic wraps naturally because the depth is a power of two.
  function automatic sb_ptr_t sb_slot(input sb_ptr_t base, input int unsigned offset);
    return base + sb_ptr_t'(offset);
  endfunction

endpackage

// File: rtl/scoreboard_if.sv
// Decode / issue / writeback / commit / operand-lookup bundle around the
// scoreboard. slave = scoreboard side, master = pipeline side.
interface scoreboard_if #(
  parameter int NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) ();
  import ariane_pkg::*;

  logic                     flush_i;
  logic                     full_o;

  scoreboard_entry          decoded_instr_i;
  logic                     decoded_instr_valid_i;
  logic                     decoded_instr_ack_o;

  scoreboard_entry          issue_instr_o;
  logic                     issue_instr_valid_o;
  logic                     issue_ack_i;

  logic [4:0]               rs1_i;
  logic [4:0]               rs2_i;
  logic [63:0]              rs1_o;
  logic [63:0]              rs2_o;
  logic                     rs1_valid_o;
  logic                     rs2_valid_o;
  logic                     rs1_busy_o;
  logic                     rs2_busy_o;

  logic [TRANS_ID_BITS-1:0] trans_id_i [NR_WB_PORTS];
  logic [63:0]              wdata_i    [NR_WB_PORTS];
  exception                 ex_i       [NR_WB_PORTS];
  logic [NR_WB_PORTS-1:0]   wb_valid_i;

  scoreboard_entry          commit_instr_o;
  logic                     commit_valid_o;
  logic                     commit_ack_i;

  modport slave (
    input  flush_i, decoded_instr_i, decoded_instr_valid_i, issue_ack_i,
           rs1_i, rs2_i, trans_id_i, wdata_i, ex_i, wb_valid_i, commit_ack_i,
    output full_o, decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o,
           rs1_o, rs2_o, rs1_valid_o, rs2_valid_o, rs1_busy_o, rs2_busy_o,
           commit_instr_o, commit_valid_o
  );

  modport master (
    output flush_i, decoded_instr_i, decoded_instr_valid_i, issue_ack_i,
           rs1_i, rs2_i, trans_id_i, wdata_i, ex_i, wb_valid_i, commit_ack_i,
    input  full_o, decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o,
           rs1_o, rs2_o, rs1_valid_o, rs2_valid_o, rs1_busy_o, rs2_busy_o,
           commit_instr_o, commit_valid_o
  );

endinterface

// File: rtl/scoreboard_sb_fwd_lookup.sv
// Combinational operand lookup: finds the youngest occupied entry writing rs
// and reports either its result (valid) or that it is still pending (busy).
module sb_fwd_lookup import scoreboard_pkg::*; #(
  parameter int NR_ENTRIES = 4,
  parameter int CNT_W      = $clog2(NR_ENTRIES + 1)
) (
  input  sb_ptr_t          commit_ptr_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [4:0]       rd_i     [NR_ENTRIES],
  input  logic             valid_i  [NR_ENTRIES],
  input  logic [63:0]      result_i [NR_ENTRIES],
  input  logic [4:0]       rs_i,
  output logic [63:0]      rs_o,
  output logic             rs_valid_o,
  output logic             rs_busy_o
);

  logic        hit;
  logic        hit_valid;
  logic [63:0] hit_result;
  sb_ptr_t     idx;

  // Walk oldest to youngest and let each later match overwrite the earlier,
  // so the surviving hit is the youngest writer.
  always_comb begin
    hit        = 1'b0;
    hit_valid  = 1'b0;
    hit_result = '0;
    idx        = commit_ptr_i;
    for (int k = 0; k < NR_ENTRIES; k++) begin
      idx = sb_slot(commit_ptr_i, unsigned'(k));
      if ((CNT_W'(k) < count_i) && (rd_i[idx] == rs_i)) begin
        hit        = 1'b1;
        hit_valid  = valid_i[idx];
        hit_result = result_i[idx];
      end
    end
  end

  always_comb begin
    rs_o       = '0;
    rs_valid_o = 1'b0;
    rs_busy_o  = 1'b0;
    if (hit && (rs_i != 5'd0)) begin
      rs_valid_o = hit_valid;
      rs_busy_o  = ~hit_valid;
      rs_o       = hit_valid ? hit_result : 64'd0;
    end
  end

endmodule

// File: rtl/scoreboard.sv
// In-flight instruction scoreboard: circular buffer between decode and commit
// with in-order issue, out-of-order writeback by trans_id and in-order commit.
module scoreboard #(
  parameter int NR_ENTRIES  = ariane_pkg::NR_SB_ENTRIES,
  parameter int NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
  input logic         clk_i,
  input logic         rst_i,
  scoreboard_if.slave sb
);
  import ariane_pkg::*;
  import scoreboard_pkg::*;

  localparam int CNT_W = $clog2(NR_ENTRIES + 1);

  scoreboard_entry  mem_q [NR_ENTRIES];
  scoreboard_entry  mem_d [NR_ENTRIES];
  sb_ptr_t          commit_ptr_q, commit_ptr_d;
  sb_ptr_t          issue_ptr_q, issue_ptr_d;
  sb_ptr_t          alloc_ptr_q, alloc_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;

  logic full;
  logic alloc_fire;
  logic issue_valid;
  logic issue_fire;
  logic commit_valid;
  logic commit_fire;

  assign full         = (count_q == CNT_W'(NR_ENTRIES));
  assign alloc_fire   = sb.decoded_instr_valid_i & ~full & ~sb.flush_i;
  assign issue_valid  = (count_q != issued_cnt_q);
  assign commit_valid = (count_q != '0) & mem_q[commit_ptr_q].valid & (issued_cnt_q != '0);
  assign issue_fire   = sb.issue_ack_i & issue_valid & ~sb.flush_i;
  assign commit_fire  = sb.commit_ack_i & commit_valid & ~sb.flush_i;

  assign sb.full_o              = full;
  assign sb.decoded_instr_ack_o = alloc_fire;
  assign sb.issue_instr_valid_o = issue_valid;
  assign sb.issue_instr_o       = mem_q[issue_ptr_q];
  assign sb.commit_valid_o      = commit_valid;
  assign sb.commit_instr_o      = mem_q[commit_ptr_q];

  always_comb begin
    mem_d        = mem_q;
    commit_ptr_d = commit_ptr_q;
    issue_ptr_d  = issue_ptr_q;
    alloc_ptr_d  = alloc_ptr_q;
    count_d      = count_q;
    issued_cnt_d = issued_cnt_q;
    if (sb.flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) mem_d[i].valid = 1'b0;
      commit_ptr_d = '0;
      issue_ptr_d  = '0;
      alloc_ptr_d  = '0;
      count_d      = '0;
      issued_cnt_d = '0;
    end else begin
      // The decoded result field carries the immediate and is kept as-is.
      if (alloc_fire) begin
        mem_d[alloc_ptr_q]          = sb.decoded_instr_i;
        mem_d[alloc_ptr_q].trans_id = alloc_ptr_q;
        mem_d[alloc_ptr_q].valid    = 1'b0;
        alloc_ptr_d                 = sb_slot(alloc_ptr_q, 1);
      end
      // Highest port first so the lowest index wins a colliding trans_id.
      for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
        if (sb.wb_valid_i[p]) begin
          mem_d[sb.trans_id_i[p]].result = sb.wdata_i[p];
          mem_d[sb.trans_id_i[p]].valid  = 1'b1;
          mem_d[sb.trans_id_i[p]].ex     = sb.ex_i[p];
        end
      end
      if (issue_fire)  issue_ptr_d  = sb_slot(issue_ptr_q, 1);
      if (commit_fire) commit_ptr_d = sb_slot(commit_ptr_q, 1);
      count_d      = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
      issued_cnt_d = issued_cnt_q + CNT_W'(issue_fire) - CNT_W'(commit_fire);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) mem_q[i] <= '0;
      commit_ptr_q <= '0;
      issue_ptr_q  <= '0;
      alloc_ptr_q  <= '0;
      count_q      <= '0;
      issued_cnt_q <= '0;
    end else begin
      mem_q        <= mem_d;
      commit_ptr_q <= commit_ptr_d;
      issue_ptr_q  <= issue_ptr_d;
      alloc_ptr_q  <= alloc_ptr_d;
      count_q      <= count_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  logic [4:0]  ent_rd     [NR_ENTRIES];
  logic        ent_valid  [NR_ENTRIES];
  logic [63:0] ent_result [NR_ENTRIES];

  for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_fields
    assign ent_rd[gi]     = mem_q[gi].rd;
    assign ent_valid[gi]  = mem_q[gi].valid;
    assign ent_result[gi] = mem_q[gi].result;
  end

  logic [63:0] rs1_data, rs2_data;
  logic        rs1_valid, rs2_valid, rs1_busy, rs2_busy;

  sb_fwd_lookup #(.NR_ENTRIES(NR_ENTRIES), .CNT_W(CNT_W)) i_fwd_rs1 (
    .commit_ptr_i (commit_ptr_q),
    .count_i      (count_q),
    .rd_i         (ent_rd),
    .valid_i      (ent_valid),
    .result_i     (ent_result),
    .rs_i         (sb.rs1_i),
    .rs_o         (rs1_data),
    .rs_valid_o   (rs1_valid),
    .rs_busy_o    (rs1_busy)
  );

  sb_fwd_lookup #(.NR_ENTRIES(NR_ENTRIES), .CNT_W(CNT_W)) i_fwd_rs2 (
    .commit_ptr_i (commit_ptr_q),
    .count_i      (count_q),
    .rd_i         (ent_rd),
    .valid_i      (ent_valid),
    .result_i     (ent_result),
    .rs_i         (sb.rs2_i),
    .rs_o         (rs2_data),
    .rs_valid_o   (rs2_valid),
    .rs_busy_o    (rs2_busy)
  );

  assign sb.rs1_o       = rs1_data;
  assign sb.rs1_valid_o = rs1_valid;
  assign sb.rs1_busy_o  = rs1_busy;
  assign sb.rs2_o       = rs2_data;
  assign sb.rs2_valid_o = rs2_valid;
  assign sb.rs2_busy_o  = rs2_busy;

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard: allocation/full, issue/writeback/commit,
// wrap-around, forwarding, flush and dual-port writeback.
module tb_scoreboard;
  import ariane_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scoreboard_if sb_if ();

  scoreboard dut (
    .clk_i (clk),
    .rst_i (rst),
    .sb    (sb_if)
  );

  int vectors     = 0;
  int miscompares = 0;

  function automatic scoreboard_entry mk(input logic [4:0] rd, input logic [63:0] imm);
    scoreboard_entry e;
    e          = '0;
    e.pc       = 64'h8000_0000;
    e.fu       = FU_ALU;
    e.rd       = rd;
    e.result   = imm;
    e.valid    = 1'b1;
    e.trans_id = '1;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.flush_i               = 1'b0;
    sb_if.decoded_instr_i       = '0;
    sb_if.decoded_instr_valid_i = 1'b0;
    sb_if.issue_ack_i           = 1'b0;
    sb_if.rs1_i                 = 5'd0;
    sb_if.rs2_i                 = 5'd0;
    sb_if.wb_valid_i            = '0;
    sb_if.commit_ack_i          = 1'b0;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      sb_if.trans_id_i[p] = '0;
      sb_if.wdata_i[p]    = '0;
      sb_if.ex_i[p]       = '0;
    end
  endtask

  task automatic wb(input int port, input logic [TRANS_ID_BITS-1:0] id, input logic [63:0] data);
    sb_if.wb_valid_i[port] = 1'b1;
    sb_if.trans_id_i[port] = id;
    sb_if.wdata_i[port]    = data;
    sb_if.ex_i[port]       = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    sb_if.rs1_i = 5'd1;
    #1;
    vectors++; if ({sb_if.full_o, sb_if.decoded_instr_ack_o, sb_if.issue_instr_valid_o, sb_if.commit_valid_o} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: got %b need 0000", {sb_if.full_o, sb_if.decoded_instr_ack_o, sb_if.issue_instr_valid_o, sb_if.commit_valid_o}); end
    vectors++; if ({sb_if.rs1_valid_o, sb_if.rs1_busy_o, sb_if.rs2_valid_o, sb_if.rs2_busy_o} !== 4'b0000 || sb_if.rs1_o !== 64'd0) begin
      miscompares++; $display("FAIL reset_fwd: got v/b %b data %0h need 0", {sb_if.rs1_valid_o, sb_if.rs1_busy_o, sb_if.rs2_valid_o, sb_if.rs2_busy_o}, sb_if.rs1_o); end
    rst = 1'b0;
    idle();
    step();
    $display("test_reset done");
  endtask

  task automatic test_alloc_full();
    for (int k = 0; k < 4; k++) begin
      sb_if.decoded_instr_i       = mk(5'(k + 1), 64'h100 + 64'(k));
      sb_if.decoded_instr_valid_i = 1'b1;
      #1;
      vectors++; if (sb_if.decoded_instr_ack_o !== 1'b1) begin
        miscompares++; $display("FAIL alloc_ack[%0d]: got %b need 1", k, sb_if.decoded_instr_ack_o); end
      step();
      vectors++; if (sb_if.issue_instr_valid_o !== 1'b1 || sb_if.issue_instr_o.trans_id !== 2'd0 || sb_if.issue_instr_o.rd !== 5'd1) begin
        miscompares++; $display("FAIL alloc_issue_head[%0d]: got v=%b id=%0d rd=%0d need v=1 id=0 rd=1", k, sb_if.issue_instr_valid_o, sb_if.issue_instr_o.trans_id, sb_if.issue_instr_o.rd); end
    end
    sb_if.decoded_instr_i = mk(5'd9, 64'h999);
    #1;
    vectors++; if (sb_if.full_o !== 1'b1 || sb_if.decoded_instr_ack_o !== 1'b0) begin
      miscompares++; $display("FAIL full_refuse: got full=%b ack=%b need full=1 ack=0", sb_if.full_o, sb_if.decoded_instr_ack_o); end
    vectors++; if (sb_if.commit_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL alloc_clears_valid: got commit_valid=%b need 0", sb_if.commit_valid_o); end
    step();
    sb_if.decoded_instr_valid_i = 1'b0;
    $display("test_alloc_full done");
  endtask

  task automatic test_wb_commit();
    sb_if.issue_ack_i = 1'b1;
    #1;
    vectors++; if (sb_if.issue_instr_valid_o !== 1'b1 || sb_if.issue_instr_o.trans_id !== 2'd0 || sb_if.issue_instr_o.result !== 64'h100) begin
      miscompares++; $display("FAIL issue0: got v=%b id=%0d imm=%0h need v=1 id=0 imm=100", sb_if.issue_instr_valid_o, sb_if.issue_instr_o.trans_id, sb_if.issue_instr_o.result); end
    step();
    sb_if.issue_ack_i = 1'b0;
    wb(0, 2'd0, 64'hDEAD);
    #1;
    vectors++; if (sb_if.commit_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL wb_no_bypass: got commit_valid=%b need 0", sb_if.commit_valid_o); end
    step();
    sb_if.wb_valid_i = '0;
    #1;
    vectors++; if (sb_if.commit_valid_o !== 1'b1 || sb_if.commit_instr_o.result !== 64'hDEAD || sb_if.commit_instr_o.trans_id !== 2'd0) begin
      miscompares++; $display("FAIL commit_head: got v=%b res=%0h id=%0d need v=1 res=dead id=0", sb_if.commit_valid_o, sb_if.commit_instr_o.result, sb_if.commit_instr_o.trans_id); end
    sb_if.commit_ack_i = 1'b1;
    step();
    sb_if.commit_ack_i = 1'b0;
    #1;
    vectors++; if (dut.count_q !== 3'd3 || sb_if.full_o !== 1'b0 || sb_if.commit_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL after_commit: got count=%0d full=%b cv=%b need count=3 full=0 cv=0", dut.count_q, sb_if.full_o, sb_if.commit_valid_o); end
    $display("test_wb_commit done");
  endtask

  task automatic test_full_commit_alloc();
    sb_if.decoded_instr_i       = mk(5'd7, 64'h700);
    sb_if.decoded_instr_valid_i = 1'b1;
    step();
    sb_if.decoded_instr_valid_i = 1'b0;
    sb_if.issue_ack_i           = 1'b1;
    #1;
    vectors++; if (sb_if.full_o !== 1'b1 || sb_if.issue_instr_o.trans_id !== 2'd1 || sb_if.issue_instr_o.rd !== 5'd2) begin
      miscompares++; $display("FAIL refill_issue1: got full=%b id=%0d rd=%0d need full=1 id=1 rd=2", sb_if.full_o, sb_if.issue_instr_o.trans_id, sb_if.issue_instr_o.rd); end
    step();
    sb_if.issue_ack_i = 1'b0;
    wb(1, 2'd1, 64'h55);
    step();
    sb_if.wb_valid_i            = '0;
    sb_if.commit_ack_i          = 1'b1;
    sb_if.decoded_instr_i       = mk(5'd8, 64'h800);
    sb_if.decoded_instr_valid_i = 1'b1;
    #1;
    vectors++; if (sb_if.commit_valid_o !== 1'b1 || sb_if.commit_instr_o.result !== 64'h55 || sb_if.decoded_instr_ack_o !== 1'b0) begin
      miscompares++; $display("FAIL full_commit_alloc: got cv=%b res=%0h ack=%b need cv=1 res=55 ack=0", sb_if.commit_valid_o, sb_if.commit_instr_o.result, sb_if.decoded_instr_ack_o); end
    step();
    sb_if.commit_ack_i = 1'b0;
    #1;
    vectors++; if (dut.count_q !== 3'd3 || sb_if.full_o !== 1'b0 || sb_if.decoded_instr_ack_o !== 1'b1) begin
      miscompares++; $display("FAIL next_alloc: got count=%0d full=%b ack=%b need count=3 full=0 ack=1", dut.count_q, sb_if.full_o, sb_if.decoded_instr_ack_o); end
    step();
    sb_if.decoded_instr_valid_i = 1'b0;
    #1;
    vectors++; if (sb_if.full_o !== 1'b1) begin
      miscompares++; $display("FAIL refull: got full=%b need 1", sb_if.full_o); end
    $display("test_full_commit_alloc done");
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ids  [4];
    logic [4:0]  rds  [4];
    logic [63:0] ress [4];
    ids  = '{2'd2, 2'd3, 2'd0, 2'd1};
    rds  = '{5'd3, 5'd4, 5'd7, 5'd8};
    ress = '{64'hC2, 64'hC3, 64'hC0, 64'hC1};
    sb_if.issue_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (sb_if.issue_instr_valid_o !== 1'b1 || sb_if.issue_instr_o.trans_id !== ids[k] || sb_if.issue_instr_o.rd !== rds[k]) begin
        miscompares++; $display("FAIL b2b_issue[%0d]: got v=%b id=%0d rd=%0d need v=1 id=%0d rd=%0d", k, sb_if.issue_instr_valid_o, sb_if.issue_instr_o.trans_id, sb_if.issue_instr_o.rd, ids[k], rds[k]); end
      step();
    end
    sb_if.issue_ack_i = 1'b0;
    #1;
    vectors++; if (sb_if.issue_instr_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL b2b_drained: got issue_valid=%b need 0", sb_if.issue_instr_valid_o); end
    wb(0, 2'd2, 64'hC2); wb(1, 2'd3, 64'hC3);
    step();
    wb(0, 2'd0, 64'hC0); wb(1, 2'd1, 64'hC1);
    step();
    sb_if.wb_valid_i   = '0;
    sb_if.commit_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (sb_if.commit_valid_o !== 1'b1 || sb_if.commit_instr_o.trans_id !== ids[k] || sb_if.commit_instr_o.result !== ress[k]) begin
        miscompares++; $display("FAIL b2b_commit[%0d]: got v=%b id=%0d res=%0h need v=1 id=%0d res=%0h", k, sb_if.commit_valid_o, sb_if.commit_instr_o.trans_id, sb_if.commit_instr_o.result, ids[k], ress[k]); end
      step();
    end
    sb_if.commit_ack_i = 1'b0;
    #1;
    vectors++; if (dut.count_q !== 3'd0 || sb_if.commit_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL b2b_empty: got count=%0d cv=%b need 0 0", dut.count_q, sb_if.commit_valid_o); end
    $display("test_back_to_back done");
  endtask

  task automatic test_forward();
    sb_if.decoded_instr_valid_i = 1'b1;
    sb_if.decoded_instr_i       = mk(5'd5, 64'hAAAA);
    step();
    sb_if.decoded_instr_i       = mk(5'd5, 64'hBBBB);
    step();
    sb_if.decoded_instr_valid_i = 1'b0;
    sb_if.rs1_i = 5'd5;
    sb_if.rs2_i = 5'd9;
    #1;
    vectors++; if (sb_if.rs1_busy_o !== 1'b1 || sb_if.rs1_valid_o !== 1'b0 || sb_if.rs1_o !== 64'd0) begin
      miscompares++; $display("FAIL fwd_pending: got b=%b v=%b d=%0h need b=1 v=0 d=0", sb_if.rs1_busy_o, sb_if.rs1_valid_o, sb_if.rs1_o); end
    vectors++; if (sb_if.rs2_busy_o !== 1'b0 || sb_if.rs2_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL fwd_nomatch: got b=%b v=%b need 0 0", sb_if.rs2_busy_o, sb_if.rs2_valid_o); end
    sb_if.issue_ack_i = 1'b1;
    step(); step();
    sb_if.issue_ack_i = 1'b0;
    wb(0, 2'd2, 64'h11);
    step();
    sb_if.wb_valid_i = '0;
    sb_if.rs2_i = 5'd5;
    #1;
    vectors++; if (sb_if.rs1_busy_o !== 1'b1 || sb_if.rs1_valid_o !== 1'b0 || sb_if.rs2_busy_o !== 1'b1) begin
      miscompares++; $display("FAIL fwd_younger_pending: got rs1 b=%b v=%b rs2 b=%b need 1 0 1", sb_if.rs1_busy_o, sb_if.rs1_valid_o, sb_if.rs2_busy_o); end
    wb(1, 2'd3, 64'h22);
    #1;
    vectors++; if (sb_if.rs1_busy_o !== 1'b1) begin
      miscompares++; $display("FAIL fwd_no_wb_bypass: got b=%b need 1", sb_if.rs1_busy_o); end
    step();
    sb_if.wb_valid_i = '0;
    #1;
    vectors++; if (sb_if.rs1_o !== 64'h22 || sb_if.rs1_valid_o !== 1'b1 || sb_if.rs1_busy_o !== 1'b0) begin
      miscompares++; $display("FAIL fwd_youngest: got d=%0h v=%b b=%b need d=22 v=1 b=0", sb_if.rs1_o, sb_if.rs1_valid_o, sb_if.rs1_busy_o); end
    $display("test_forward done");
  endtask

  task automatic test_flush();
    sb_if.decoded_instr_valid_i = 1'b1;
    sb_if.decoded_instr_i       = mk(5'd0, 64'hC);
    step();
    sb_if.decoded_instr_valid_i = 1'b0;
    sb_if.rs1_i = 5'd0;
    sb_if.rs2_i = 5'd5;
    #1;
    vectors++; if (dut.count_q !== 3'd3 || sb_if.rs1_busy_o !== 1'b0 || sb_if.rs1_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL x0_lookup: got count=%0d b=%b v=%b need 3 0 0", dut.count_q, sb_if.rs1_busy_o, sb_if.rs1_valid_o); end
    sb_if.flush_i               = 1'b1;
    sb_if.decoded_instr_valid_i = 1'b1;
    sb_if.decoded_instr_i       = mk(5'd9, 64'h900);
    wb(0, 2'd0, 64'h99);
    #1;
    vectors++; if (sb_if.decoded_instr_ack_o !== 1'b0) begin
      miscompares++; $display("FAIL flush_blocks_alloc: got ack=%b need 0", sb_if.decoded_instr_ack_o); end
    step();
    sb_if.flush_i               = 1'b0;
    sb_if.wb_valid_i            = '0;
    sb_if.decoded_instr_valid_i = 1'b0;
    #1;
    vectors++; if (dut.count_q !== 3'd0 || sb_if.commit_valid_o !== 1'b0 || sb_if.issue_instr_valid_o !== 1'b0 || sb_if.rs2_valid_o !== 1'b0 || sb_if.full_o !== 1'b0) begin
      miscompares++; $display("FAIL flush_state: got count=%0d cv=%b iv=%b rs2v=%b full=%b need all 0", dut.count_q, sb_if.commit_valid_o, sb_if.issue_instr_valid_o, sb_if.rs2_valid_o, sb_if.full_o); end
    sb_if.decoded_instr_valid_i = 1'b1;
    step();
    sb_if.decoded_instr_valid_i = 1'b0;
    #1;
    vectors++; if (sb_if.issue_instr_valid_o !== 1'b1 || sb_if.issue_instr_o.trans_id !== 2'd0 || sb_if.issue_instr_o.rd !== 5'd9) begin
      miscompares++; $display("FAIL flush_realloc: got v=%b id=%0d rd=%0d need v=1 id=0 rd=9", sb_if.issue_instr_valid_o, sb_if.issue_instr_o.trans_id, sb_if.issue_instr_o.rd); end
    $display("test_flush done");
  endtask

  task automatic test_dual_wb();
    logic [63:0] ress [4];
    ress = '{64'hA0, 64'hA1, 64'h2222, 64'h3333};
    sb_if.decoded_instr_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb_if.decoded_instr_i = mk(5'(10 + k), 64'h0);
      step();
    end
    sb_if.decoded_instr_valid_i = 1'b0;
    sb_if.issue_ack_i = 1'b1;
    repeat (4) step();
    sb_if.issue_ack_i = 1'b0;
    wb(0, 2'd2, 64'h2222); wb(1, 2'd3, 64'h3333);
    step();
    sb_if.wb_valid_i = '0;
    sb_if.rs1_i = 5'd11;
    sb_if.rs2_i = 5'd12;
    #1;
    vectors++; if (sb_if.commit_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL dual_head_pending: got cv=%b need 0", sb_if.commit_valid_o); end
    vectors++; if (sb_if.rs1_valid_o !== 1'b1 || sb_if.rs1_o !== 64'h2222 || sb_if.rs2_valid_o !== 1'b1 || sb_if.rs2_o !== 64'h3333) begin
      miscompares++; $display("FAIL dual_wb_both: got %b/%0h %b/%0h need 1/2222 1/3333", sb_if.rs1_valid_o, sb_if.rs1_o, sb_if.rs2_valid_o, sb_if.rs2_o); end
    wb(0, 2'd0, 64'hA0); wb(1, 2'd1, 64'hA1);
    step();
    sb_if.wb_valid_i   = '0;
    sb_if.commit_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (sb_if.commit_valid_o !== 1'b1 || sb_if.commit_instr_o.trans_id !== 2'(k) || sb_if.commit_instr_o.result !== ress[k]) begin
        miscompares++; $display("FAIL dual_commit[%0d]: got v=%b id=%0d res=%0h need v=1 id=%0d res=%0h", k, sb_if.commit_valid_o, sb_if.commit_instr_o.trans_id, sb_if.commit_instr_o.result, k, ress[k]); end
      step();
    end
    sb_if.commit_ack_i = 1'b0;
    #1;
    vectors++; if (sb_if.commit_valid_o !== 1'b0 || dut.count_q !== 3'd0) begin
      miscompares++; $display("FAIL dual_empty: got cv=%b count=%0d need 0 0", sb_if.commit_valid_o, dut.count_q); end
    $display("test_dual_wb done");
  endtask

  initial begin
    test_reset();
    test_alloc_full();
    test_wb_commit();
    test_full_commit_alloc();
    test_back_to_back();
    test_forward();
    test_flush();
    test_dual_wb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scoreboard.md
# scoreboard

Tracks in-flight instructions in a circular buffer of `scoreboard_entry` records between decode and commit. It allocates transaction IDs, presents the oldest un-issued entry to the execute stage, and collects results from the writeback ports by `trans_id`. It forwards operands and busy status for rs1/rs2 and presents the oldest entry to the commit stage in program order.

## Interface
- `NR_ENTRIES`, default `NR_SB_ENTRIES` (4): buffer depth; must be a power of two.
- `NR_WB_PORTS`, default `NR_WB_PORTS` (2): number of writeback ports.
- `clk_i`  in  1: clock; one clock domain.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `flush_i`  in  1: discard all entries.
- `full_o`  out  1: all NR_ENTRIES slots occupied.
- `decoded_instr_i`  in  scoreboard_entry: new instruction from decode.
- `decoded_instr_valid_i`  in  1: decode offers an entry.
- `decoded_instr_ack_o`  out  1: entry accepted this cycle.
- `issue_instr_o`  out  scoreboard_entry: oldest un-issued entry, `trans_id` filled in.
- `issue_instr_valid_o`  out  1: `issue_instr_o` is meaningful.
- `issue_ack_i`  in  1: execute accepted `issue_instr_o`.
- `rs1_i`, `rs2_i`  in  5 each: operand register addresses to look up.
- `rs1_o`, `rs2_o`  out  64 each: forwarded result.
- `rs1_valid_o`, `rs2_valid_o`  out  1 each: a forwarded value is available.
- `rs1_busy_o`, `rs2_busy_o`  out  1 each: a pending writer exists with no result yet.
- `trans_id_i`  in  [NR_WB_PORTS][TRANS_ID_BITS]: writeback target entry.
- `wdata_i`  in  [NR_WB_PORTS][64]: writeback result.
- `ex_i`  in  [NR_WB_PORTS] exception: writeback exception.
- `wb_valid_i`  in  [NR_WB_PORTS]: writeback strobe.
- `commit_instr_o`  out  scoreboard_entry: head entry.
- `commit_valid_o`  out  1: head is occupied and its result is valid.
- `commit_ack_i`  in  1: commit retires the head.

## Operation
- State:
  - `mem[NR_ENTRIES]` of scoreboard_entry.
  - `commit_ptr`, `issue_ptr`, `alloc_ptr`, each TRANS_ID_BITS wide and wrapping modulo NR_ENTRIES.
  - `count` (0..NR_ENTRIES, $clog2(NR_ENTRIES+1) bits).
  - `issued_cnt` (0..count).
- Allocate:
  - `decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i`.
  - On ack: `mem[alloc_ptr] <= decoded_instr_i` with `trans_id <= alloc_ptr` and `valid <= 0`; the incoming `result` (the immediate) is kept. Then `alloc_ptr++`.
- Issue:
  - `issue_instr_valid_o = (count != issued_cnt)`; `issue_instr_o = mem[issue_ptr]`.
  - On `issue_ack_i & issue_instr_valid_o`: `issue_ptr++`, `issued_cnt++`.
- Writeback:
  - For each port p with `wb_valid_i[p]`: `mem[trans_id_i[p]].result <= wdata_i[p]`, `.valid <= 1`, `.ex <= ex_i[p]`.
  - Two ports targeting the same id is a protocol violation; the lower port index wins.
- Commit:
  - `commit_valid_o = (count != 0) & mem[commit_ptr].valid & (issued_cnt != 0)`; `commit_instr_o = mem[commit_ptr]`.
  - On ack: `commit_ptr++`, `count--`, `issued_cnt--`.
- Lookup (rs1 and rs2 identical):
  - Scan occupied entries with `rd == rs` from youngest to oldest; the first match decides.
  - Match with `valid` set: `valid_o = 1`, `rs_o = result`.
  - Match without `valid`: `busy_o = 1`.
  - No match, or `rs == 0`: all outputs 0.
- `full_o = (count == NR_ENTRIES)`, taken from registered state. Commit does not bypass into allocate in the same cycle.
- Flush: all pointers, `count` and `issued_cnt` go to 0 and every `mem[i].valid` to 0 on the next edge. Flush overrides same-cycle allocate, issue, writeback and commit.
- Simultaneous allocate and commit: `count` unchanged. Simultaneous issue and commit: `issued_cnt` unchanged.
- Reset: same effect as flush. `mem` contents need not be reset except the `valid` bits.

## Timing
- Reset values:
  - 0: `full_o`, `decoded_instr_ack_o`, `issue_instr_valid_o`, `commit_valid_o`, `rs*_valid_o`, `rs*_busy_o`, `rs*_o`.
  - `issue_instr_o` and `commit_instr_o` reflect `mem[0]`, which is don't-care.
- All outputs are combinational from registered state and same-cycle inputs. No input-to-output path from the `wb_*` ports.
- Allocated entry is visible on `issue_instr_o` one cycle after ack.
- A writeback in cycle t sets `commit_valid_o` and the forward outputs in cycle t+1.
- Minimum decode-to-commit latency: 3 cycles (allocate, issue, writeback) with 1-cycle execute.
- Throughput: one allocate, one issue, one commit and NR_WB_PORTS writebacks per cycle.

## Structure
- In ariane_pkg: `scoreboard_entry`, `exception`, `fu_t`, `NR_SB_ENTRIES`, `TRANS_ID_BITS`, `NR_WB_PORTS`. No new package types are needed.
- One sub-module, `sb_fwd_lookup`: combinational youngest-match search. Instantiated twice, for rs1 and rs2.

## Test plan
- Reset, then allocate 4 entries (rd=1..4) with no commit → `full_o=1` after the 4th ack; 5th valid gets `ack=0`; trans_ids 0,1,2,3.
- Issue id0, write back on port 0 with `wdata=64'hDEAD` → next cycle `commit_valid_o=1`, `commit_instr_o.result=64'hDEAD`; ack → count 3.
- Two entries with rd=5: older written back with 64'h11, younger still pending; `rs1_i=5` → `rs1_busy_o=1`, `rs1_valid_o=0`. After the younger is written back with 64'h22 → `rs1_o=64'h22`, `rs1_valid_o=1`.
- Full buffer, head valid, commit ack and decode valid in the same cycle → commit accepted, allocate refused. Next cycle allocate accepted with trans_id = old commit_ptr (wrap-around).
- Both writeback ports hit ids 2 and 3 in the same cycle → both `valid` set; subsequent commits retire in order 0,1,2,3.
- Flush with 3 entries and a same-cycle writeback → next cycle `count=0`, `commit_valid_o=0`, `issue_instr_valid_o=0`; the next allocation gets trans_id 0.
